rv32_if_id_fifo: RTL

RV32_IF_ID_FIFO -- requirements
Module: rv32_if_id_fifo

---
 rtl/rv32_pkg.sv | 15 +
 rtl/rv32_iq_storage.sv | 46 ++++
 rtl/rv32_if_id_fifo.sv | 74 +++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 front-end definitions: NOP encoding, default queue depth and entry layout.
// Used by the IF/ID FIFO and by the ID/EX queue flush logic.
package rv32_pkg;

   localparam int unsigned IQ_DEPTH = 4;

   // ADDI x0,x0,0
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] code;
      logic [31:0] pc;
   } iq_entry_t;

endpackage

// File: rtl/rv32_iq_storage.sv
// Circular instruction buffer: one write port, one asynchronous read port, wrapping pointers.
// Entry contents are never reset; only the pointers are.
module rv32_iq_storage
   import rv32_pkg::*;
#(
   parameter int unsigned DEPTH = IQ_DEPTH
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic        clear,
   input  logic [31:0] wr_code,
   input  logic [31:0] wr_pc,
   output logic [31:0] rd_code,
   output logic [31:0] rd_pc
);

   localparam int unsigned PW = $clog2(DEPTH);

   iq_entry_t     mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // DEPTH is a power of two, so natural PW-bit overflow wraps DEPTH-1 back to 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PW'(1);
         if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= '{code: wr_code, pc: wr_pc};
   end

   assign rd_code = mem[rd_ptr].code;
   assign rd_pc   = mem[rd_ptr].pc;

endmodule

// File: rtl/rv32_if_id_fifo.sv
// IF/ID instruction FIFO: first-word-fall-through, flushable, with occupancy count.
// Handshake, occupancy and flush live here; storage and pointers are in rv32_iq_storage.
module rv32_if_id_fifo
   import rv32_pkg::*;
#(
   parameter int unsigned DEPTH = IQ_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     fetch_valid,
   input  logic [31:0]              code_in,
   input  logic [31:0]              pc_in,
   output logic                     fetch_ready,
   input  logic                     flush,
   input  logic                     busy,
   output logic [31:0]              code_out,
   output logic [31:0]              pc_out,
   output logic                     valid_out,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic          full;
   logic          push;
   logic          pop;
   logic [31:0]   head_code;
   logic [31:0]   head_pc;

   assign full        = (count_q == CW'(DEPTH));
   assign valid_out   = (count_q != '0);
   // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
   assign fetch_ready = !full && !flush;
   assign push        = fetch_valid && fetch_ready;
   assign pop         = valid_out && !busy && !flush;

   always_comb begin
      count_d = count_q;
      if (flush) begin
         count_d = '0;
      end else if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   rv32_iq_storage #(
      .DEPTH (DEPTH)
   ) u_storage (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (push),
      .rd_en   (pop),
      .clear   (flush),
      .wr_code (code_in),
      .wr_pc   (pc_in),
      .rd_code (head_code),
      .rd_pc   (head_pc)
   );

   // Empty FIFO presents a harmless NOP so decode never sees stale storage.
   assign code_out = valid_out ? head_code : NOP_INSN;
   assign pc_out   = valid_out ? head_pc   : 32'h0;
   assign count    = count_q;

endmodule
